register_file_16x16: RTL and testbench

REGISTER_FILE_16X16 -- requirements
Module: register_file_16x16

---
 rtl/regfile_pkg.sv | 14 +
 rtl/write_decoder_4_16.sv | 17 +
 rtl/register_file_16x16.sv | 111 +++++++++++
 tb/tb_register_file_16x16.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 16x16 register file.
//   DATA_W   : register width in bits
//   ADDR_W   : register-ID width
//   NUM_REGS : number of architectural registers (2**ADDR_W)
//   reg_id_t : register identifier type
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_id_t;

endpackage

// File: rtl/write_decoder_4_16.sv
// One-hot decoder from a register ID to a register wordline.
// Ports:
//   RegId    : input  register ID
//   Wordline : output one-hot vector, bit i set when RegId == i
module write_decoder_4_16
  import regfile_pkg::*;
(
  input  reg_id_t               RegId,
  output logic [NUM_REGS-1:0]   Wordline
);

  always_comb begin
    Wordline        = '0;
    Wordline[RegId] = 1'b1;
  end

endmodule

// File: rtl/register_file_16x16.sv
// 16-entry register file with two combinational read ports, one write
// port and a per-register pending-producer scoreboard.
// R0 is hardwired to zero and can never be marked pending.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a write in
// progress is forwarded to a matching read port in the same cycle and the
// port's busy flag is suppressed.
// Ports:
//   clk      : clock, all state updates on rising edge
//   rst_n    : asynchronous active-low reset
//   SrcReg1  : read port 1 register ID
//   SrcReg2  : read port 2 register ID
//   DstReg   : write port register ID
//   WriteReg : write enable
//   DstData  : write data
//   IssueEn  : mark IssueReg as having a pending producer
//   IssueReg : destination register of the issuing instruction
//   SrcData1 : read data, port 1
//   SrcData2 : read data, port 2
//   Busy1    : port 1 source has an unresolved pending write
//   Busy2    : port 2 source has an unresolved pending write
module register_file_16x16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] SrcReg1,
  input  logic [ADDR_W-1:0] SrcReg2,
  input  logic [ADDR_W-1:0] DstReg,
  input  logic              WriteReg,
  input  logic [DATA_W-1:0] DstData,
  input  logic              IssueEn,
  input  logic [ADDR_W-1:0] IssueReg,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2,
  output logic              Busy1,
  output logic              Busy2
);

  import regfile_pkg::NUM_REGS;
  import regfile_pkg::reg_id_t;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [NUM_REGS-1:0] wr_wl;
  logic [NUM_REGS-1:0] iss_wl;
  logic [DATA_W-1:0]   rd1;
  logic [DATA_W-1:0]   rd2;
  logic                bsy1;
  logic                bsy2;

  write_decoder_4_16 u_wr_dec (
    .RegId    (reg_id_t'(DstReg)),
    .Wordline (wr_wl)
  );

  write_decoder_4_16 u_iss_dec (
    .RegId    (reg_id_t'(IssueReg)),
    .Wordline (iss_wl)
  );

  // Clear on write first, then set on issue so a new producer issued in
  // the same cycle as the old one's writeback keeps the register pending.
  always_comb begin
    pending_nxt = pending;
    if (WriteReg) pending_nxt = pending_nxt & ~wr_wl;
    if (IssueEn)  pending_nxt = pending_nxt | iss_wl;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (WriteReg && wr_wl[i]) regs[i] <= DstData;
      end
      pending <= pending_nxt;
    end
  end

  always_comb begin
    rd1  = (SrcReg1 == '0) ? '0 : regs[SrcReg1];
    rd2  = (SrcReg2 == '0) ? '0 : regs[SrcReg2];
    bsy1 = pending[SrcReg1];
    bsy2 = pending[SrcReg2];
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write; R0 is excluded so it always reads 0.
    if (WriteReg && (DstReg != '0) && (DstReg == SrcReg1)) begin
      rd1  = DstData;
      bsy1 = 1'b0;
    end
    if (WriteReg && (DstReg != '0) && (DstReg == SrcReg2)) begin
      rd2  = DstData;
      bsy2 = 1'b0;
    end
`else
    // Without forwarding a same-cycle write becomes visible next cycle.
`endif
  end

  // Outputs are forced low while reset is held, which also hides any
  // forwarded write data during reset.
  assign SrcData1 = rst_n ? rd1  : '0;
  assign SrcData2 = rst_n ? rd2  : '0;
  assign Busy1    = rst_n & bsy1;
  assign Busy2    = rst_n & bsy2;

endmodule

// File: tb/tb_register_file_16x16.sv
module tb_register_file_16x16;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  SrcReg1, SrcReg2, DstReg, IssueReg;
  logic        WriteReg, IssueEn;
  logic [15:0] DstData;
  logic [15:0] SrcData1, SrcData2;
  logic        Busy1, Busy2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  register_file_16x16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .DstReg   (DstReg),
    .WriteReg (WriteReg),
    .DstData  (DstData),
    .IssueEn  (IssueEn),
    .IssueReg (IssueReg),
    .SrcData1 (SrcData1),
    .SrcData2 (SrcData2),
    .Busy1    (Busy1),
    .Busy2    (Busy2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WriteReg = 1'b0;
    IssueEn  = 1'b0;
    DstReg   = 4'd0;
    IssueReg = 4'd0;
    DstData  = 16'h0000;
  endtask

  initial begin
    rst_n = 1'b0;
    SrcReg1 = 4'd5;
    SrcReg2 = 4'd0;
    idle();
    #2;
    push("reset_data1", 16'h0000);     chk(SrcData1);
    push("reset_busy1", 16'h0000);     chk({15'd0, Busy1});
    @(negedge clk);
    rst_n = 1'b1;

    // Write R5 and issue R6 together, then reset mid-cycle.
    DstReg = 4'd5; DstData = 16'h1234; WriteReg = 1'b1;
    IssueReg = 4'd6; IssueEn = 1'b1;
    tick();
    idle();
    SrcReg1 = 4'd5; SrcReg2 = 4'd6;
    #1;
    push("r5_written", 16'h1234);      chk(SrcData1);
    push("r6_pending", 16'h0001);      chk({15'd0, Busy2});
    #1;
    rst_n = 1'b0;
    #1;
    push("async_rst_data1", 16'h0000); chk(SrcData1);
    push("async_rst_busy1", 16'h0000); chk({15'd0, Busy1});
    push("async_rst_busy2", 16'h0000); chk({15'd0, Busy2});
    // Write/issue held across an edge while in reset must be discarded.
    DstReg = 4'd5; DstData = 16'hFFFF; WriteReg = 1'b1;
    IssueReg = 4'd6; IssueEn = 1'b1;
    #1;
    push("rst_hides_write", 16'h0000); chk(SrcData1);
    tick();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    push("rst_discard_wr", 16'h0000);  chk(SrcData1);
    push("rst_discard_iss", 16'h0000); chk({15'd0, Busy2});

    // Basic write/read, both ports on the same register.
    tick();
    DstReg = 4'd3; DstData = 16'hBEEF; WriteReg = 1'b1;
    tick();
    idle();
    SrcReg1 = 4'd3; SrcReg2 = 4'd3;
    #1;
    push("r3_port1", 16'hBEEF);        chk(SrcData1);
    push("r3_port2", 16'hBEEF);        chk(SrcData2);

    // R0 is hardwired, including during a same-cycle write.
    SrcReg1 = 4'd0; SrcReg2 = 4'd0;
    DstReg = 4'd0; DstData = 16'hFFFF; WriteReg = 1'b1;
    #1;
    push("r0_during_wr1", 16'h0000);   chk(SrcData1);
    push("r0_during_wr2", 16'h0000);   chk(SrcData2);
    tick();
    idle();
    #1;
    push("r0_after_wr1", 16'h0000);    chk(SrcData1);
    push("r0_after_wr2", 16'h0000);    chk(SrcData2);

    // Same-cycle write visibility on R7.
    DstReg = 4'd7; DstData = 16'h0001; WriteReg = 1'b1;
    tick();
    idle();
    SrcReg1 = 4'd3; SrcReg2 = 4'd7;
    DstReg = 4'd7; DstData = 16'h00A5; WriteReg = 1'b1;
    #1;
    push("r7_same_cycle", BYP ? 16'h00A5 : 16'h0001); chk(SrcData2);
    push("r3_undisturbed", 16'hBEEF);  chk(SrcData1);
    tick();
    idle();
    #1;
    push("r7_next_cycle", 16'h00A5);   chk(SrcData2);

    // Scoreboard on R9.
    IssueReg = 4'd9; IssueEn = 1'b1;
    tick();
    idle();
    SrcReg1 = 4'd9;
    #1;
    push("r9_busy", 16'h0001);         chk({15'd0, Busy1});
    tick();
    push("r9_busy_hold", 16'h0001);    chk({15'd0, Busy1});
    DstReg = 4'd9; DstData = 16'h0042; WriteReg = 1'b1;
    #1;
    push("r9_busy_wrcyc", BYP ? 16'h0000 : 16'h0001); chk({15'd0, Busy1});
    push("r9_data_wrcyc", BYP ? 16'h0042 : 16'h0000); chk(SrcData1);
    tick();
    idle();
    #1;
    push("r9_busy_clear", 16'h0000);   chk({15'd0, Busy1});
    push("r9_data", 16'h0042);         chk(SrcData1);

    // Simultaneous issue and write on R4: set wins, data still written.
    IssueReg = 4'd4; IssueEn = 1'b1;
    tick();
    IssueReg = 4'd4; IssueEn = 1'b1;
    DstReg = 4'd4; DstData = 16'h5555; WriteReg = 1'b1;
    tick();
    idle();
    SrcReg1 = 4'd4;
    #1;
    push("r4_still_busy", 16'h0001);   chk({15'd0, Busy1});
    push("r4_data", 16'h5555);         chk(SrcData1);

    // Issue to R0 is a no-op.
    IssueReg = 4'd0; IssueEn = 1'b1;
    tick();
    idle();
    SrcReg1 = 4'd0;
    #1;
    push("r0_never_busy", 16'h0000);   chk({15'd0, Busy1});

    // Idle cycle leaves state untouched.
    tick();
    SrcReg1 = 4'd3; SrcReg2 = 4'd4;
    #1;
    push("idle_r3", 16'hBEEF);         chk(SrcData1);
    push("idle_r4_busy", 16'h0001);    chk({15'd0, Busy2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
